// File: rtl/scan_sequencer_if.sv
// Host/Transmitter-facing bundle of the scan sequencer; err_timeout exists only when SCAN_TIMEOUT_EN is defined.
// master = host + Transmitter side, slave = the sequencer itself.
interface scan_sequencer_if #(
    parameter int ANGLE_DW = 8,
    parameter int DW_INPUT = 8,
    parameter int PTS_DW   = 10,
    parameter int HOLD_DW  = 16
);
    logic                start;
    logic                abort;
    logic [ANGLE_DW-1:0] cfg_angle_start;
    logic [ANGLE_DW-1:0] cfg_angle_end;
    logic [ANGLE_DW-1:0] cfg_angle_step;
    logic [DW_INPUT-1:0] cfg_r0_start;
    logic [DW_INPUT-1:0] cfg_r0_step;
    logic [PTS_DW-1:0]   cfg_num_points;
    logic [HOLD_DW-1:0]  cfg_holdoff;
    logic                tx_done;
    logic                tx_initiate;
    logic [ANGLE_DW-1:0] tx_angle;
    logic [DW_INPUT-1:0] tx_r0;
    logic [PTS_DW-1:0]   point_idx;
    logic                busy;
    logic                line_done;
    logic                frame_done;
`ifdef SCAN_TIMEOUT_EN
    logic                err_timeout;
`endif

    modport master (
        output start, abort, cfg_angle_start, cfg_angle_end, cfg_angle_step,
               cfg_r0_start, cfg_r0_step, cfg_num_points, cfg_holdoff, tx_done,
        input  tx_initiate, tx_angle, tx_r0, point_idx, busy, line_done, frame_done
`ifdef SCAN_TIMEOUT_EN
        , input err_timeout
`endif
    );

    modport slave (
        input  start, abort, cfg_angle_start, cfg_angle_end, cfg_angle_step,
               cfg_r0_start, cfg_r0_step, cfg_num_points, cfg_holdoff, tx_done,
        output tx_initiate, tx_angle, tx_r0, point_idx, busy, line_done, frame_done
`ifdef SCAN_TIMEOUT_EN
        , output err_timeout
`endif
    );
endinterface

// File: rtl/scan_sequencer.sv
// Frame controller: per angle, issues num_points initiates (r_0 stepped, saturating); next initiate 1+done wait+holdoff+1 cycles later.
// Waits on tx_done with no backpressure otherwise; abort returns to IDLE at once. SCAN_TIMEOUT_EN adds a done watchdog.
module scan_sequencer #(
    parameter int ANGLE_DW    = 8,
    parameter int DW_INPUT    = 8,
    parameter int PTS_DW      = 10,
    parameter int HOLD_DW     = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic             clk,
    input logic             rst,
    scan_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, HOLDOFF, NEXT, FRAME_END} state_t;

    state_t              state;
    logic [ANGLE_DW-1:0] angle_end_q;
    logic [ANGLE_DW-1:0] angle_step_q;
    logic [DW_INPUT-1:0] r0_start_q;
    logic [DW_INPUT-1:0] r0_step_q;
    logic [PTS_DW-1:0]   num_points_q;
    logic [HOLD_DW-1:0]  holdoff_q;
    logic [HOLD_DW-1:0]  hold_cnt;

    logic [DW_INPUT:0]   r0_sum;
    logic [DW_INPUT-1:0] r0_next;
    logic [ANGLE_DW:0]   angle_sum;
    logic                accept;
    logic                last_point;
    logic                angle_stop;

`ifdef SCAN_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [WD_W-1:0] wd_cnt;
`endif

    assign accept     = bus.start && !bus.abort && (bus.cfg_num_points != '0) &&
                        (bus.cfg_angle_start <= bus.cfg_angle_end);
    assign last_point = (bus.point_idx == (num_points_q - PTS_DW'(1)));
    assign r0_sum     = {1'b0, bus.tx_r0} + {1'b0, r0_step_q};
    assign r0_next    = r0_sum[DW_INPUT] ? {DW_INPUT{1'b1}} : r0_sum[DW_INPUT-1:0];
    assign angle_sum  = {1'b0, bus.tx_angle} + {1'b0, angle_step_q};
    // Carry out means the next angle cannot be represented, so the frame is over.
    assign angle_stop = (angle_step_q == '0) || angle_sum[ANGLE_DW] ||
                        (angle_sum[ANGLE_DW-1:0] > angle_end_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            angle_end_q     <= '0;
            angle_step_q    <= '0;
            r0_start_q      <= '0;
            r0_step_q       <= '0;
            num_points_q    <= '0;
            holdoff_q       <= '0;
            hold_cnt        <= '0;
            bus.tx_initiate <= 1'b0;
            bus.tx_angle    <= '0;
            bus.tx_r0       <= '0;
            bus.point_idx   <= '0;
            bus.busy        <= 1'b0;
            bus.line_done   <= 1'b0;
            bus.frame_done  <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
            wd_cnt          <= '0;
            bus.err_timeout <= 1'b0;
`endif
        end else begin
            bus.tx_initiate <= 1'b0;
            bus.line_done   <= 1'b0;
            bus.frame_done  <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        angle_end_q     <= bus.cfg_angle_end;
                        angle_step_q    <= bus.cfg_angle_step;
                        r0_start_q      <= bus.cfg_r0_start;
                        r0_step_q       <= bus.cfg_r0_step;
                        num_points_q    <= bus.cfg_num_points;
                        holdoff_q       <= bus.cfg_holdoff;
                        bus.tx_angle    <= bus.cfg_angle_start;
                        bus.tx_r0       <= bus.cfg_r0_start;
                        bus.point_idx   <= '0;
                        bus.tx_initiate <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= ISSUE;
`ifdef SCAN_TIMEOUT_EN
                        bus.err_timeout <= 1'b0;
`endif
                    end
                    ISSUE: begin
                        state <= WAIT_DONE;
`ifdef SCAN_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                    WAIT_DONE: begin
                        if (bus.tx_done) begin
                            hold_cnt <= holdoff_q;
                            state    <= (holdoff_q == '0) ? NEXT : HOLDOFF;
                        end
`ifdef SCAN_TIMEOUT_EN
                        else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                            bus.err_timeout <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + WD_W'(1);
                        end
`endif
                    end
                    HOLDOFF: begin
                        hold_cnt <= hold_cnt - HOLD_DW'(1);
                        if (hold_cnt == HOLD_DW'(1)) state <= NEXT;
                    end
                    NEXT: begin
                        if (!last_point) begin
                            bus.point_idx   <= bus.point_idx + PTS_DW'(1);
                            bus.tx_r0       <= r0_next;
                            bus.tx_initiate <= 1'b1;
                            state           <= ISSUE;
                        end else begin
                            bus.line_done <= 1'b1;
                            bus.point_idx <= '0;
                            bus.tx_r0     <= r0_start_q;
                            if (angle_stop) begin
                                bus.frame_done <= 1'b1;
                                state          <= FRAME_END;
                            end else begin
                                bus.tx_angle    <= angle_sum[ANGLE_DW-1:0];
                                bus.tx_initiate <= 1'b1;
                                state           <= ISSUE;
                            end
                        end
                    end
                    FRAME_END: begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized bench for scan_sequencer: scan points are predicted from the frame rules and checked on every initiate.
module tb_scan_sequencer;
    localparam int ANGLE_DW = 8, DW_INPUT = 8, PTS_DW = 10, HOLD_DW = 16, TIMEOUT_CYC = 100;

    typedef struct {int angle; int r0; int idx;} pt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_sequencer_if #(.ANGLE_DW(ANGLE_DW), .DW_INPUT(DW_INPUT), .PTS_DW(PTS_DW), .HOLD_DW(HOLD_DW)) bus ();

    scan_sequencer #(.ANGLE_DW(ANGLE_DW), .DW_INPUT(DW_INPUT), .PTS_DW(PTS_DW), .HOLD_DW(HOLD_DW),
                     .TIMEOUT_CYC(TIMEOUT_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int  n_pass = 0, n_chk = 0;
    pt_t exp_q[$];
    int  exp_lines;
    int  cyc = 0, last_init = 0, n_init = 0;
    int  line_cnt = 0, frame_cnt = 0;
    bit  first_init = 1'b1;
    int  hold_cur = 0, last_d = 0, dmin = 1, dmax = 1;
    bit  resp_en = 1'b1;
    logic resp_done = 1'b0, man_done = 1'b0;

    assign bus.tx_done = resp_done | man_done;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected scan points of one frame, straight from the angle/point stepping rules.
    task automatic build_model(input int as, input int ae, input int st, input int r0s, input int r0st, input int np);
        int a, r;
        exp_q.delete();
        exp_lines = 0;
        if (np == 0 || as > ae) return;
        a = as;
        while (1) begin
            exp_lines++;
            for (int p = 0; p < np; p++) begin
                r = r0s + p * r0st;
                if (r > 255) r = 255;
                exp_q.push_back('{angle: a, r0: r, idx: p});
            end
            if (st == 0 || a + st > ae || a + st > 255) break;
            a = a + st;
        end
    endtask

    // Monitor: every initiate must match the next predicted point and keep the expected spacing.
    always @(negedge clk) begin
        pt_t p;
        cyc++;
        if (bus.tx_initiate) begin
            n_init++;
            check("initiate expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                check("tx_angle", int'(bus.tx_angle), p.angle);
                check("tx_r0", int'(bus.tx_r0), p.r0);
                check("point_idx", int'(bus.point_idx), p.idx);
            end
            if (!first_init) check("initiate spacing", cyc - last_init, 2 + last_d + hold_cur);
            first_init = 1'b0;
            last_init  = cyc;
        end
        if (bus.line_done) line_cnt++;
        if (bus.frame_done) frame_cnt++;
    end

    // Transmitter stand-in: one done pulse d cycles after each initiate.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (bus.tx_initiate && resp_en) begin
                d = $urandom_range(dmax, dmin);
                repeat (d) @(negedge clk);
                last_d    = d;
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    task automatic set_cfg(input int as, input int ae, input int st, input int r0s, input int r0st, input int np, input int h);
        bus.cfg_angle_start = ANGLE_DW'(as);
        bus.cfg_angle_end   = ANGLE_DW'(ae);
        bus.cfg_angle_step  = ANGLE_DW'(st);
        bus.cfg_r0_start    = DW_INPUT'(r0s);
        bus.cfg_r0_step     = DW_INPUT'(r0st);
        bus.cfg_num_points  = PTS_DW'(np);
        bus.cfg_holdoff     = HOLD_DW'(h);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input int as, input int ae, input int st, input int r0s, input int r0st,
                             input int np, input int h, input int dlo, input int dhi);
        int busy_seen, n0;
        set_cfg(as, ae, st, r0s, r0st, np, h);
        build_model(as, ae, st, r0s, r0st, np);
        hold_cur = h; dmin = dlo; dmax = dhi;
        line_cnt = 0; frame_cnt = 0; first_init = 1'b1; n0 = n_init;
        pulse_start();
        if (np != 0 && as <= ae) begin
            // Latched config must shield the running frame from input changes.
            set_cfg($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0),
                    $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(9, 1), $urandom_range(9, 0));
            for (int i = 0; i < 20000 && frame_cnt == 0; i++) @(negedge clk);
            check("frame_done count", frame_cnt, 1);
            check("line_done count", line_cnt, exp_lines);
            check("points left", exp_q.size(), 0);
            @(negedge clk);
            check("busy after frame", int'(bus.busy), 0);
        end else begin
            busy_seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (bus.busy) busy_seen++;
                @(negedge clk);
            end
            check("ignored start busy", busy_seen, 0);
            check("ignored start initiates", n_init - n0, 0);
        end
    endtask

    initial begin
        int n0, k;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset tx_initiate", int'(bus.tx_initiate), 0);
        check("reset tx_angle", int'(bus.tx_angle), 0);
        check("reset tx_r0", int'(bus.tx_r0), 0);
        check("reset point_idx", int'(bus.point_idx), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset line/frame_done", int'({bus.line_done, bus.frame_done}), 0);
`ifdef SCAN_TIMEOUT_EN
        check("reset err_timeout", int'(bus.err_timeout), 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reference frame; model pinned to hand-computed values first.
        build_model(60, 64, 2, 10, 5, 4);
        check("model point count", exp_q.size(), 12);
        check("model r0 of point 3", exp_q[3].r0, 25);
        check("model last angle", exp_q[11].angle, 64);
        run_frame(60, 64, 2, 10, 5, 4, 3, 5, 5);

        run_frame(60, 64, 2, 10, 5, 0, 3, 5, 5);
        run_frame(70, 60, 2, 10, 5, 4, 3, 5, 5);

        build_model(10, 10, 1, 250, 4, 3);
        check("model saturated r0", exp_q[2].r0, 255);
        run_frame(10, 10, 1, 250, 4, 3, 2, 1, 4);

        // Abort together with tx_done while waiting for done.
        resp_en = 1'b0;
        set_cfg(20, 40, 5, 7, 3, 4, 2);
        build_model(20, 40, 5, 7, 3, 4);
        line_cnt = 0; frame_cnt = 0; first_init = 1'b1; n0 = n_init;
        pulse_start();
        for (int i = 0; i < 20 && n_init == n0; i++) @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1; man_done = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; man_done = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort tx_initiate", int'(bus.tx_initiate), 0);
        repeat (3) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (5) @(negedge clk);
        check("abort late done busy", int'(bus.busy), 0);
        check("abort line_done", line_cnt, 0);
        check("abort frame_done", frame_cnt, 0);
        exp_q.delete();
        resp_en = 1'b1;
        run_frame(20, 40, 5, 7, 3, 4, 2, 1, 3);

        build_model(250, 255, 10, 0, 1, 1);
        check("model overflow points", exp_q.size(), 1);
        run_frame(250, 255, 10, 0, 1, 1, 0, 1, 3);
        run_frame(5, 9, 0, 100, 50, 3, 1, 2, 2);

        for (int t = 0; t < 8; t++) begin
            int as, ae;
            as = $urandom_range(255, 0);
            ae = as + $urandom_range(20, 0);
            if (ae > 255) ae = 255;
            run_frame(as, ae, $urandom_range(6, 0), $urandom_range(255, 0), $urandom_range(80, 0),
                      $urandom_range(6, 1), $urandom_range(5, 0), 1, 6);
        end

        // Reset mid-frame clears every output.
        set_cfg(33, 99, 3, 44, 2, 5, 1);
        build_model(33, 99, 3, 44, 2, 5);
        hold_cur = 1; first_init = 1'b1; n0 = n_init;
        pulse_start();
        for (int i = 0; i < 20 && n_init == n0; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst tx_angle", int'(bus.tx_angle), 0);
        check("mid rst tx_r0", int'(bus.tx_r0), 0);
        check("mid rst busy", int'(bus.busy), 0);
        repeat (20) @(negedge clk);
        check("mid rst stays idle", int'(bus.busy), 0);
        exp_q.delete();

`ifdef SCAN_TIMEOUT_EN
        resp_en = 1'b0;
        set_cfg(1, 1, 1, 2, 1, 1, 0);
        build_model(1, 1, 1, 2, 1, 1);
        first_init = 1'b1;
        pulse_start();
        k = 0;
        while (bus.busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("timeout busy drop cycle", k, TIMEOUT_CYC + 1);
        check("timeout err set", int'(bus.err_timeout), 1);
        resp_en = 1'b1;
        run_frame(1, 1, 1, 2, 1, 1, 0, 1, 2);
        check("timeout err cleared", int'(bus.err_timeout), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
